// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline issue controller: instruction layout,
// func codes and operand-usage decode.
package pipe_ctrl_pkg;

  localparam int INSTR_W  = 24;
  localparam int FUNC_W   = 4;
  localparam int REG_W    = 4;
  localparam int ADDR_W   = 8;
  localparam int FUNC_LSB = 20;
  localparam int RD_LSB   = 16;
  localparam int RS1_LSB  = 12;
  localparam int RS2_LSB  = 8;
  localparam int ADDR_LSB = 0;

  localparam logic [FUNC_W-1:0] F_ADD = 4'd0;
  localparam logic [FUNC_W-1:0] F_SUB = 4'd1;
  localparam logic [FUNC_W-1:0] F_AND = 4'd2;
  localparam logic [FUNC_W-1:0] F_NOT = 4'd3;
  localparam logic [FUNC_W-1:0] F_LD  = 4'd4;
  localparam logic [FUNC_W-1:0] F_OR  = 4'd5;
  localparam logic [FUNC_W-1:0] F_XOR = 4'd6;
  localparam logic [FUNC_W-1:0] F_CMP = 4'd7;
  localparam logic [FUNC_W-1:0] F_MOV = 4'd8;
  localparam logic [FUNC_W-1:0] F_ST  = 4'd9;
  localparam logic [FUNC_W-1:0] F_SHR = 4'd10;
  localparam logic [FUNC_W-1:0] F_SHL = 4'd11;

  // Field order matches the packed 24-bit instruction word, MSB first.
  typedef struct packed {
    logic [FUNC_W-1:0] func;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [ADDR_W-1:0] addr;
  } instr_t;

  function automatic logic is_illegal(input logic [FUNC_W-1:0] func);
    return func >= 4'd12;
  endfunction

  function automatic logic uses_rs1(input logic [FUNC_W-1:0] func);
    return (func <= F_NOT) || (func >= F_OR && func <= F_MOV) ||
           func == F_SHR || func == F_SHL;
  endfunction

  function automatic logic uses_rs2(input logic [FUNC_W-1:0] func);
    return (func <= F_AND) || (func >= F_LD && func <= F_CMP) || func == F_ST;
  endfunction

endpackage

// File: rtl/pipe_scoreboard.sv
// Per-register write-pending counters. A register is busy while its counter
// is nonzero; each requester gets its own pair of source-register queries.
module pipe_scoreboard
  import pipe_ctrl_pkg::*;
#(
  parameter int PIPE_DEPTH = 2,
  parameter int NREG       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [REG_W-1:0]      set_rd,
  input  logic [1:0][REG_W-1:0] q1,
  input  logic [1:0][REG_W-1:0] q2,
  output logic [1:0]            busy1,
  output logic [1:0]            busy2
);

  localparam int CW = $clog2(PIPE_DEPTH + 2);
  localparam logic [CW-1:0] LOAD = CW'(PIPE_DEPTH + 1);

  logic [CW-1:0] cnt [NREG];

  // Load on a new writer (restarts any pending count), otherwise count down.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (set_en && set_rd == REG_W'(i)) cnt[i] <= LOAD;
        else if (cnt[i] != '0)             cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

  // Busy lookup for both requesters' source registers.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      busy1[k] = cnt[q1[k]] != '0;
      busy2[k] = cnt[q2[k]] != '0;
    end
  end

endmodule

// File: rtl/pipe_issue_ctrl.sv
// Two-requester round-robin issue controller with RAW hazard holdback,
// producing one registered issue slot per cycle for the pipeline.
module pipe_issue_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int PIPE_DEPTH = 2,
  parameter int NREG       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  input  logic [INSTR_W-1:0] req0_instr,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [INSTR_W-1:0] req1_instr,
  output logic               req1_ready,
  input  logic               hold,
  output logic               iss_valid,
  output logic [FUNC_W-1:0]  iss_func,
  output logic [REG_W-1:0]   iss_rd,
  output logic [REG_W-1:0]   iss_rs1,
  output logic [REG_W-1:0]   iss_rs2,
  output logic [ADDR_W-1:0]  iss_addr,
  output logic               iss_src,
  output logic               err_illegal,
  output logic [15:0]        issue_count
);

  instr_t                  ins [2];
  logic [1:0]              valid_v;
  logic [1:0]              elig;
  logic [1:0][REG_W-1:0]   q1;
  logic [1:0][REG_W-1:0]   q2;
  logic [1:0]              busy1;
  logic [1:0]              busy2;
  logic                    prio;
  logic                    gnt;
  logic                    gidx;
  instr_t                  sel;
  logic                    sel_ill;
  logic                    set_en;

  assign ins[0]  = instr_t'(req0_instr);
  assign ins[1]  = instr_t'(req1_instr);
  assign valid_v = {req1_valid, req0_valid};

  pipe_scoreboard #(
    .PIPE_DEPTH (PIPE_DEPTH),
    .NREG       (NREG)
  ) u_sb (
    .clk    (clk),
    .rst    (rst),
    .set_en (set_en),
    .set_rd (sel.rd),
    .q1     (q1),
    .q2     (q2),
    .busy1  (busy1),
    .busy2  (busy2)
  );

  // Eligibility per requester; illegal funcs skip the hazard check since
  // they are dropped rather than issued.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      q1[k]   = ins[k].rs1;
      q2[k]   = ins[k].rs2;
      elig[k] = valid_v[k] && !hold && !rst &&
                (is_illegal(ins[k].func) ||
                 (!(uses_rs1(ins[k].func) && busy1[k]) &&
                  !(uses_rs2(ins[k].func) && busy2[k])));
    end
  end

  // Round-robin pick; an ineligible requester falls out so the other wins.
  always_comb begin
    gnt        = |elig;
    gidx       = (&elig) ? prio : elig[1];
    req0_ready = gnt && !gidx;
    req1_ready = gnt && gidx;
    sel        = gidx ? ins[1] : ins[0];
    sel_ill    = is_illegal(sel.func);
    set_en     = gnt && !sel_ill;
  end

  // Issue register, error pulse, issue counter and priority pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_valid   <= 1'b0;
      iss_func    <= '0;
      iss_rd      <= '0;
      iss_rs1     <= '0;
      iss_rs2     <= '0;
      iss_addr    <= '0;
      iss_src     <= 1'b0;
      err_illegal <= 1'b0;
      issue_count <= '0;
      prio        <= 1'b0;
    end else begin
      iss_valid   <= set_en;
      err_illegal <= gnt && sel_ill;
      if (set_en) begin
        iss_func    <= sel.func;
        iss_rd      <= sel.rd;
        iss_rs1     <= sel.rs1;
        iss_rs2     <= sel.rs2;
        iss_addr    <= sel.addr;
        iss_src     <= gidx;
        issue_count <= issue_count + 16'd1;
      end
      if (gnt) prio <= !gidx;
    end
  end

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Bench for pipe_issue_ctrl: directed scenarios followed by random traffic,
// all compared against a cycle-count based reference model.
module tb_pipe_issue_ctrl;

  localparam int PD = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0;
  logic [23:0] req0_instr = '0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [23:0] req1_instr = '0;
  logic        req1_ready;
  logic        hold = 1'b0;
  logic        iss_valid;
  logic [3:0]  iss_func, iss_rd, iss_rs1, iss_rs2;
  logic [7:0]  iss_addr;
  logic        iss_src;
  logic        err_illegal;
  logic [15:0] issue_count;

  int total = 0;
  int bad   = 0;

  // Reference model state: a register is writable-visible from free_at[r] on.
  int          cyc;
  int          free_at [16];
  bit          prio_m;
  int          cnt_m;
  logic [23:0] fld_m;
  bit          src_m;
  bit          vld_m;
  bit          err_m;
  int          g_last;
  int          g_cyc;
  int          g0_cyc;
  int          g1_cnt;

  pipe_issue_ctrl #(.PIPE_DEPTH(PD), .NREG(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_instr  (req0_instr),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_instr  (req1_instr),
    .req1_ready  (req1_ready),
    .hold        (hold),
    .iss_valid   (iss_valid),
    .iss_func    (iss_func),
    .iss_rd      (iss_rd),
    .iss_rs1     (iss_rs1),
    .iss_rs2     (iss_rs2),
    .iss_addr    (iss_addr),
    .iss_src     (iss_src),
    .err_illegal (err_illegal),
    .issue_count (issue_count)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] mk(int f, int rd, int s1, int s2, int a);
    return {4'(f), 4'(rd), 4'(s1), 4'(s2), 8'(a)};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit elig_m(bit v, logic [23:0] ins);
    int f;
    bit u1, u2;
    f = int'(ins[23:20]);
    if (!v || hold) return 1'b0;
    if (f >= 12) return 1'b1;
    u1 = f inside {0, 1, 2, 3, 5, 6, 7, 8, 10, 11};
    u2 = f inside {0, 1, 2, 4, 5, 6, 7, 9};
    if (u1 && cyc < free_at[ins[15:12]]) return 1'b0;
    if (u2 && cyc < free_at[ins[11:8]]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_reset();
    cyc = 0; prio_m = 0; cnt_m = 0; fld_m = '0; src_m = 0; vld_m = 0; err_m = 0;
    for (int r = 0; r < 16; r++) free_at[r] = 0;
  endfunction

  // One clock cycle: inputs already driven at edge+1.
  task automatic step();
    bit e0, e1, g;
    int gi;
    logic [23:0] ins;
    #3;
    e0 = elig_m(req0_valid, req0_instr);
    e1 = elig_m(req1_valid, req1_instr);
    g  = e0 || e1;
    gi = (e0 && e1) ? int'(prio_m) : (e1 ? 1 : 0);
    chk("ready0", 32'(req0_ready), 32'(g && gi == 0));
    chk("ready1", 32'(req1_ready), 32'(g && gi == 1));
    @(posedge clk);
    #1;
    vld_m = 0; err_m = 0; g_last = -1;
    if (g) begin
      ins = (gi == 1) ? req1_instr : req0_instr;
      g_last = gi; g_cyc = cyc;
      if (gi == 0) g0_cyc = cyc; else g1_cnt++;
      if (ins[23:20] >= 12) err_m = 1;
      else begin
        vld_m = 1; fld_m = ins; src_m = bit'(gi);
        cnt_m = (cnt_m + 1) % 65536;
        free_at[ins[19:16]] = cyc + PD + 2;
      end
      prio_m = (gi == 0);
    end
    cyc++;
    chk("iss_valid", 32'(iss_valid), 32'(vld_m));
    chk("err_illegal", 32'(err_illegal), 32'(err_m));
    chk("iss_fields", 32'({iss_func, iss_rd, iss_rs1, iss_rs2, iss_addr}), 32'(fld_m));
    chk("iss_src", 32'(iss_src), 32'(src_m));
    chk("issue_count", 32'(issue_count), 32'(cnt_m));
  endtask

  // Assert reset asynchronously between edges, verify zeros, release.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_valid", 32'(iss_valid), 32'd0);
    chk("rst_err", 32'(err_illegal), 32'd0);
    chk("rst_fields", 32'({iss_func, iss_rd, iss_rs1, iss_rs2, iss_addr, iss_src}), 32'd0);
    chk("rst_count", 32'(issue_count), 32'd0);
    chk("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int seq [4];
    model_reset();
    g_last = -1; g_cyc = -1; g0_cyc = -1; g1_cnt = 0;
    @(posedge clk);
    #1;
    do_reset();

    // Single legal issue.
    req0_valid = 1; req0_instr = mk(0, 3, 1, 2, 8'h5A);
    step();
    req0_valid = 0;
    chk("tp1_rd", 32'(iss_rd), 32'd3);
    chk("tp1_count", 32'(issue_count), 32'd1);
    step();

    // RAW stall on rd=3.
    do_reset();
    req0_valid = 1; req0_instr = mk(0, 3, 1, 2, 1);
    step();
    req0_instr = mk(1, 4, 3, 0, 2);
    g_cyc = -1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (g_last == 0) break;
    end
    chk("tp2_hs_cycle", 32'(g_cyc), 32'd4);
    req0_valid = 0;
    step();

    // Alternating grants with both independent.
    do_reset();
    req0_valid = 1; req0_instr = mk(0, 4, 0, 1, 3);
    req1_valid = 1; req1_instr = mk(5, 5, 0, 1, 4);
    for (int i = 0; i < 4; i++) begin
      step();
      seq[i] = g_last;
    end
    chk("tp3_seq", 32'({4'(seq[0]), 4'(seq[1]), 4'(seq[2]), 4'(seq[3])}), 32'h0101);

    // req0 blocked on hazard, req1 keeps going.
    do_reset();
    req0_valid = 0; req1_valid = 1; req1_instr = mk(0, 3, 1, 2, 0);
    step();
    req0_valid = 1; req0_instr = mk(1, 9, 3, 3, 0);
    req1_instr = mk(0, 6, 7, 8, 0);
    g0_cyc = -1; g1_cnt = 0;
    for (int i = 0; i < 4; i++) step();
    chk("tp4_req1_grants", 32'(g1_cnt), 32'd3);
    chk("tp4_req0_cycle", 32'(g0_cyc), 32'd4);

    // Illegal func, then hold.
    req0_valid = 0; req1_valid = 1; req1_instr = mk(13, 2, 3, 4, 5);
    step();
    chk("tp5_err", 32'(err_illegal), 32'd1);
    req0_valid = 1; req0_instr = mk(0, 10, 11, 12, 0);
    req1_instr = mk(2, 13, 11, 12, 0);
    hold = 1;
    step();
    step();
    hold = 0;
    step();

    // Reset during a stall discards the hazard.
    do_reset();
    req1_valid = 0;
    req0_valid = 1; req0_instr = mk(0, 3, 1, 2, 0);
    step();
    req0_instr = mk(1, 4, 3, 0, 0);
    step();
    do_reset();
    g_cyc = -1;
    step();
    chk("tp6_no_stall", 32'(g_cyc), 32'd0);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      req0_valid = ($urandom_range(0, 9) < 7);
      req1_valid = ($urandom_range(0, 9) < 7);
      hold       = ($urandom_range(0, 99) < 15);
      req0_instr = mk($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 255));
      req1_instr = mk($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 255));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_issue_ctrl.md
# pipe_issue_ctrl

Issue controller and arbiter in front of the two-clock register-bank/ALU/memory pipeline. Two requesters present packed instructions over valid/ready. The block arbitrates round-robin and holds back any instruction whose source register is still being written by an in-flight instruction (RAW hazard). It drives one registered issue slot per cycle into the pipeline's stage-1 inputs (rs1, rs2, rd, func, addr).

## Interface
Parameters:
- PIPE_DEPTH, 2: cycles from issue until the pipeline's register-bank write is visible; sets the hazard window.
- NREG, 16: register-bank entries; rd/rs fields are log2(NREG) = 4 bits.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an instruction.
- req0_instr  in  24  {func[23:20], rd[19:16], rs1[15:12], rs2[11:8], addr[7:0]}.
- req0_ready  out  1  combinational grant; transfer when valid && ready.
- req1_valid / req1_instr / req1_ready: same as requester 0.
- hold  in  1  downstream freeze; no new issue while high.
- iss_valid  out  1  registered issue strobe.
- iss_func, iss_rd, iss_rs1, iss_rs2  out  4 each  registered fields of the issued instruction.
- iss_addr  out  8  registered memory address.
- iss_src  out  1  requester of the issued instruction.
- err_illegal  out  1  one-cycle pulse: an illegal func (12–15) was consumed.
- issue_count  out  16  count of issued instructions, wraps at 65535→0.

## Operation
- Operand use by func:
  - 0–2, 5–7: rs1 and rs2.
  - 3, 8, 10, 11: rs1 only.
  - 4, 9: rs2 only.
  - 12–15: illegal, no hazard check.
- Scoreboard: one down-counter per register, width clog2(PIPE_DEPTH+2).
  - On handshake of a legal instruction, cnt[rd] is loaded with PIPE_DEPTH+1. The load has priority over decrement.
  - Otherwise each nonzero counter decrements by 1 every cycle, including while hold is high.
- Eligible: valid && !hold && every used source register has cnt == 0. Illegal instructions are eligible whenever valid && !hold.
- Arbitration: pointer prio (reset 0).
  - Both eligible: grant req[prio].
  - One eligible: grant it.
  - After any grant, prio becomes the other requester.
  - An ineligible requester never blocks the other one.
- At most one ready per cycle. Ready is never asserted for a requester that is not valid.
- Legal grant: the next cycle has iss_valid=1 with its fields, iss_src = granted index, and issue_count+1.
- Illegal grant: the instruction is consumed and dropped. The next cycle has iss_valid=0 and err_illegal=1. The scoreboard and count are unchanged.
- rd == rs1 in the same instruction is allowed; only already in-flight writers cause a stall.
- A WAW sequence to the same rd needs no stall; the later load restarts the counter.

## Timing
- Handshake at cycle N → iss_* valid during N+1 (latency 1).
- Dependent instruction (source = earlier rd) can handshake no earlier than N+PIPE_DEPTH+2. With default parameters that is N+4, leaving 3 bubble cycles.
- Independent instructions issue back to back, one per cycle.
- hold high in cycle N: both ready=0, and iss_valid=0 in N+1. Counters keep decrementing.
- Reset (asynchronous, any time, including mid-stall):
  - All outputs 0: iss_valid, err_illegal, ready, iss fields, iss_src, issue_count.
  - All counters 0 and prio=0.
  - In-flight hazard tracking is discarded.

## Structure
- Package pipe_ctrl_pkg:
  - func code constants (ADD=0 … SHL=11).
  - instr field offsets/widths.
  - functions uses_rs1(func), uses_rs2(func), is_illegal(func).
- Sub-module pipe_scoreboard, holding the NREG counters:
  - inputs: set_en, set_rd, two query addresses.
  - outputs: busy1, busy2.
  - instantiated once.

## Test plan
- Reset then req0 ADD rd=3, rs1=1, rs2=2 at cycle 0 → iss_valid=1, iss_rd=3, iss_src=0 in cycle 1; issue_count=1.
- ADD rd=3 at cycle 0, then req0 SUB rs1=3 held valid → req0_ready=0 in cycles 1–3, handshake in cycle 4, issue in cycle 5.
- Both requesters valid and independent for 4 cycles from reset → grants alternate 0,1,0,1; iss_src follows the same sequence one cycle later.
- req0 blocked on hazard (rs1=3 busy) while req1 is independent → req1 granted every cycle; req0 granted once cnt[3]=0.
- req1 func=13 → consumed in 1 cycle, err_illegal pulse, iss_valid=0, issue_count unchanged. hold=1 for 2 cycles with both valid → no ready, no issue.
- Assert rst during a stall of a dependent instruction → outputs 0 immediately; after release the dependent instruction issues with no stall.
